dsp_p_result_serializer: RTL and testbench



---
 rtl/dsp48a1_pkg.sv | 21 ++
 rtl/dsp_p_result_serializer_if.sv | 44 ++++
 rtl/dsp_p_result_serializer.sv | 94 +++++++++
 tb/tb_dsp_p_result_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared types and sizing helpers for the DSP48A1 slice readback path.
// Holds default P/word widths, the serializer state enum and beat-count helpers.
package dsp48a1_pkg;

  localparam int P_WIDTH_DEF    = 48;
  localparam int WORD_WIDTH_DEF = 16;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic int nbeats(input int p_w, input int w_w);
    return p_w / w_w;
  endfunction

  function automatic int beat_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsp_p_result_serializer_if.sv
// Handshake bundle for the P result serializer: wide P+carry input stream,
// narrow word output stream. slave = serializer side, master = producer/consumer side.
interface dsp_p_result_serializer_if
  import dsp48a1_pkg::*;
#(
  parameter int P_WIDTH    = P_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [P_WIDTH-1:0]    p_in;
  logic                  carry_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_word;
  logic                  out_last;
  logic                  out_carry;

  modport slave (
    input  in_valid,
    output in_ready,
    input  p_in,
    input  carry_in,
    output out_valid,
    input  out_ready,
    output out_word,
    output out_last,
    output out_carry
  );

  modport master (
    output in_valid,
    input  in_ready,
    output p_in,
    output carry_in,
    input  out_valid,
    output out_ready,
    input  out_word,
    input  out_last,
    input  out_carry
  );

endinterface

// File: rtl/dsp_p_result_serializer.sv
// Splits one registered P result (+CARRYOUT) into NBEATS narrow words.
// Ports: clk, rst (sync, active-high), clkE (clock enable), bus (slave modport).
module dsp_p_result_serializer
  import dsp48a1_pkg::*;
#(
  parameter int P_WIDTH    = P_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter bit LSW_FIRST  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clkE,
  dsp_p_result_serializer_if.slave   bus
);

  localparam int NBEATS = nbeats(P_WIDTH, WORD_WIDTH);
  localparam int BW     = beat_bits(NBEATS);
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

  if ((P_WIDTH % WORD_WIDTH) != 0) begin : g_bad_width
    $error("P_WIDTH must be a multiple of WORD_WIDTH");
  end

  state_t  state;
  state_t  state_n;
  logic [BW-1:0] beat;
  logic [BW-1:0] beat_n;
  logic [BW-1:0] idx;
  logic [NBEATS-1:0][WORD_WIDTH-1:0] shreg;
  logic    carry;
  logic    cap;
  logic    is_last;
  logic    in_xfer;
  logic    out_xfer;

  assign is_last = (state == SEND) && (beat == LAST);

  // Last beat passes out_ready straight through so the
  // next result can load in the same cycle (no bubble).
  assign bus.in_ready  = (state == IDLE) | (is_last & bus.out_ready);
  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = is_last;
  assign bus.out_carry = is_last & carry;

  assign idx = LSW_FIRST ? beat : (LAST - beat);
  assign bus.out_word = (state == SEND) ? shreg[idx] : '0;

  assign in_xfer  = bus.in_valid & bus.in_ready & clkE;
  assign out_xfer = bus.out_valid & bus.out_ready & clkE;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_xfer) begin
          cap     = 1'b1;
          beat_n  = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (is_last) begin
            beat_n = '0;
            if (in_xfer) cap = 1'b1;
            else state_n = IDLE;
          end else begin
            beat_n = beat + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      shreg <= '0;
      carry <= 1'b0;
    end else if (clkE) begin
      state <= state_n;
      beat  <= beat_n;
      if (cap) begin
        shreg <= bus.p_in;
        carry <= bus.carry_in;
      end
    end
  end

endmodule

// File: tb/tb_dsp_p_result_serializer.sv
// Scoreboard bench for dsp_p_result_serializer: one LSW-first and one
// MSW-first instance; a negedge monitor pops expected words per transfer.
module tb_dsp_p_result_serializer;
  import dsp48a1_pkg::*;

  typedef struct packed {
    logic [15:0] w;
    logic        l;
    logic        c;
  } exp_t;

  logic clk;
  logic rst;
  logic clkE;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  dsp_p_result_serializer_if #(.P_WIDTH(48), .WORD_WIDTH(16)) ia ();
  dsp_p_result_serializer_if #(.P_WIDTH(48), .WORD_WIDTH(16)) ib ();

  dsp_p_result_serializer #(
    .P_WIDTH(48), .WORD_WIDTH(16), .LSW_FIRST(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .clkE(clkE), .bus(ia)
  );

  dsp_p_result_serializer #(
    .P_WIDTH(48), .WORD_WIDTH(16), .LSW_FIRST(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .clkE(clkE), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] w, input logic l, input logic c);
    qa.push_back('{w: w, l: l, c: c});
  endtask

  task automatic push_b(input logic [15:0] w, input logic l, input logic c);
    qb.push_back('{w: w, l: l, c: c});
  endtask

  task automatic drain(input int which, input int exp_cyc, input string nm);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
    end while ((((which == 0) ? qa.size() : qb.size()) != 0) && cnt < 40);
    chk(nm, 64'(cnt), 64'(exp_cyc));
  endtask

  always @(negedge clk) begin
    if (!rst && clkE && ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_word", {ia.out_word, ia.out_last, ia.out_carry}, 64'hDEAD_BEEF);
      end else begin
        ea = qa.pop_front();
        chk("a_beat", {ia.out_word, ia.out_last, ia.out_carry}, {ea.w, ea.l, ea.c});
      end
    end
    if (!rst && clkE && ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_word", {ib.out_word, ib.out_last, ib.out_carry}, 64'hDEAD_BEEF);
      end else begin
        eb = qb.pop_front();
        chk("b_beat", {ib.out_word, ib.out_last, ib.out_carry}, {eb.w, eb.l, eb.c});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    clkE         = 1'b1;
    ia.in_valid  = 1'b1;
    ia.p_in      = 48'h1234_5678_9ABC;
    ia.carry_in  = 1'b1;
    ia.out_ready = 1'b1;
    ib.in_valid  = 1'b0;
    ib.p_in      = '0;
    ib.carry_in  = 1'b0;
    ib.out_ready = 1'b1;

    // reset with in_valid high
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
      chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
      chk("rst_out_word", 64'(ia.out_word), 64'd0);
    end
    @(posedge clk); #1;
    rst         = 1'b0;
    ia.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_capture", 64'(ia.out_valid), 64'd0);

    // LSW first
    @(posedge clk); #1;
    push_a(16'h9ABC, 1'b0, 1'b0);
    push_a(16'h5678, 1'b0, 1'b0);
    push_a(16'h1234, 1'b1, 1'b1);
    ia.in_valid = 1'b1;
    ia.p_in     = 48'h1234_5678_9ABC;
    ia.carry_in = 1'b1;
    @(negedge clk);
    chk("t1_in_ready_idle", 64'(ia.in_ready), 64'd1);
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    ia.p_in     = 48'hDEAD_DEAD_DEAD;
    ia.carry_in = 1'b0;
    @(negedge clk);
    chk("t1_latency", 64'(ia.out_valid), 64'd1);
    chk("t1_in_ready_busy", 64'(ia.in_ready), 64'd0);
    drain(0, 3, "t1_cycles");

    // MSW first
    #1;
    push_b(16'h1234, 1'b0, 1'b0);
    push_b(16'h5678, 1'b0, 1'b0);
    push_b(16'h9ABC, 1'b1, 1'b1);
    ib.in_valid = 1'b1;
    ib.p_in     = 48'h1234_5678_9ABC;
    ib.carry_in = 1'b1;
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
    ib.carry_in = 1'b0;
    @(negedge clk);
    chk("t2_latency", 64'(ib.out_valid), 64'd1);
    drain(1, 3, "t2_cycles");

    // back-to-back
    #1;
    push_a(16'h0001, 1'b0, 1'b0);
    push_a(16'h0000, 1'b0, 1'b0);
    push_a(16'h0000, 1'b1, 1'b0);
    push_a(16'hFFFF, 1'b0, 1'b0);
    push_a(16'hFFFF, 1'b0, 1'b0);
    push_a(16'hFFFF, 1'b1, 1'b1);
    ia.in_valid = 1'b1;
    ia.p_in     = 48'h0000_0000_0001;
    ia.carry_in = 1'b0;
    @(posedge clk); #1;
    ia.p_in     = 48'hFFFF_FFFF_FFFF;
    ia.carry_in = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_beat0", 64'(ia.in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t3_in_ready_beat3", 64'(ia.in_ready), 64'd1);
    chk("t3_last_beat3", 64'(ia.out_last), 64'd1);
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_no_bubble", 64'(ia.out_valid), 64'd1);
    drain(0, 3, "t3_cycles");

    // backpressure then clkE freeze
    #1;
    push_a(16'h9ABC, 1'b0, 1'b0);
    push_a(16'h5678, 1'b0, 1'b0);
    push_a(16'h1234, 1'b1, 1'b0);
    ia.in_valid = 1'b1;
    ia.p_in     = 48'h1234_5678_9ABC;
    ia.carry_in = 1'b0;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    @(posedge clk); #1;
    ia.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_word", 64'(ia.out_word), 64'h5678);
      chk("t4_stall_in_ready", 64'(ia.in_ready), 64'd0);
      chk("t4_stall_last", 64'(ia.out_last), 64'd0);
      @(posedge clk);
    end
    #1;
    ia.out_ready = 1'b1;
    clkE         = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t4_ce_word", 64'(ia.out_word), 64'h5678);
      chk("t4_ce_valid", 64'(ia.out_valid), 64'd1);
      chk("t4_ce_in_ready", 64'(ia.in_ready), 64'd0);
      @(posedge clk);
    end
    #1;
    clkE = 1'b1;
    drain(0, 2, "t4_cycles");

    // reset mid-result
    #1;
    push_a(16'h9ABC, 1'b0, 1'b0);
    ia.in_valid = 1'b1;
    ia.p_in     = 48'h1234_5678_9ABC;
    ia.carry_in = 1'b1;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 64'(ia.out_valid), 64'd0);
    chk("t5_rst_in_ready", 64'(ia.in_ready), 64'd1);
    @(posedge clk); #1;
    push_a(16'h5555, 1'b0, 1'b0);
    push_a(16'hAAAA, 1'b0, 1'b0);
    push_a(16'h0000, 1'b1, 1'b0);
    ia.in_valid = 1'b1;
    ia.p_in     = 48'h0000_AAAA_5555;
    ia.carry_in = 1'b0;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    drain(0, 3, "t5_cycles");

    repeat (3) @(posedge clk);
    chk("end_qa_empty", 64'(qa.size()), 64'd0);
    chk("end_qb_empty", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
